// File: rtl/tpu_dma_pkg.sv
// Shared types and constants for the scratchpad stream DMA.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpu_dma_pkg;

   localparam int LEN_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      FIN  = 2'd3
   } dma_state_e;

   typedef enum logic {
      DMA_WR = 1'b0,
      DMA_RD = 1'b1
   } dma_dir_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO for the read-return path; power-of-two depth.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: full/count exposed; pushes when full and pops when empty are dropped.
module stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_dat  = mem[rd_ptr];

   // Storage array; contents are only meaningful behind the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; push+pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/scratchpad_stream_dma.sv
// Stream<->scratchpad DMA: AXI-Stream beats become sequential word writes, word reads become stream beats.
// Latency: WR/RD entered the cycle after start; read data reaches m_tvalid RD_LATENCY+1 cycles after sp_rd_en.
// Backpressure: s_tready only in WR; reads are credit-limited so in-flight returns always fit the return FIFO.
module scratchpad_stream_dma
   import tpu_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   dir,
   input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
   input  logic [LEN_WIDTH-1:0]   cfg_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic [DATA_WIDTH-1:0]  s_tdata,
   input  logic                   s_tvalid,
   input  logic                   s_tlast,
   output logic                   s_tready,
   output logic [DATA_WIDTH-1:0]  m_tdata,
   output logic                   m_tlast,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [ADDR_WIDTH-1:0]  sp_base_addr,
   output logic                   sp_wr_en,
   output logic [DATA_WIDTH-1:0]  sp_wr_data,
   output logic [LEN_WIDTH-1:0]   sp_write_pointer,
   output logic                   sp_rd_en,
   output logic [LEN_WIDTH-1:0]   sp_read_pointer,
   input  logic [DATA_WIDTH-1:0]  sp_rd_data
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDIT_LIM = FIFO_DEPTH[CW:0];

   dma_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   len_m1;
   logic [LEN_WIDTH-1:0]   ptr_q;
   logic [LEN_WIDTH-1:0]   sent_q;
   logic                   err_q;
   logic [CW-1:0]          outstanding_q;
   logic [RD_LATENCY-1:0]  vld_sr;
   logic                   ret_vld;
   logic [CW-1:0]          fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CW:0]            credit_used;
   logic                   start_acc;
   logic                   set_err;
   logic                   pop;

   assign len_m1           = len_q - 16'd1;
   assign ret_vld          = vld_sr[RD_LATENCY-1];
   assign credit_used      = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign busy             = (state_q != IDLE);
   assign err              = err_q;
   assign sp_base_addr     = base_q;
   assign sp_write_pointer = ptr_q;
   assign sp_read_pointer  = ptr_q;
   assign sp_wr_data       = s_tdata;
   assign m_tvalid         = !fifo_empty;
   assign pop              = m_tvalid && m_tready;
   assign m_tlast          = m_tvalid && (sent_q == len_m1);

   // Next-state and strobe decode; a write beat errs when tlast and the final pointer disagree.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      set_err   = 1'b0;
      s_tready  = 1'b0;
      sp_wr_en  = 1'b0;
      sp_rd_en  = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               if (cfg_len == '0)        state_d = FIN;
               else if (dir == DMA_RD)   state_d = RD;
               else                      state_d = WR;
            end
         end
         WR: begin
            s_tready = 1'b1;
            if (s_tvalid) begin
               sp_wr_en = 1'b1;
               set_err  = (ptr_q == len_m1) ^ s_tlast;
               if ((ptr_q == len_m1) || s_tlast) state_d = FIN;
            end
         end
         RD: begin
            sp_rd_en = (ptr_q < len_q) && (credit_used < CREDIT_LIM);
            if (pop && (sent_q == len_m1)) state_d = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus per-transfer context (base, length, pointer, sent count, sticky error).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         ptr_q   <= '0;
         sent_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            base_q <= cfg_base_addr;
            len_q  <= cfg_len;
            ptr_q  <= '0;
            sent_q <= '0;
            err_q  <= 1'b0;
         end else begin
            if (sp_wr_en || sp_rd_en) ptr_q  <= ptr_q + 16'd1;
            if (pop)                  sent_q <= sent_q + 16'd1;
            if (set_err)              err_q  <= 1'b1;
         end
      end
   end

   // Read-latency tracker and outstanding count; together with FIFO count they form the read credit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr        <= '0;
         outstanding_q <= '0;
      end else begin
         vld_sr[0] <= sp_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
         case ({sp_rd_en, ret_vld})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   stream_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_ret_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ret_vld && !fifo_full),
      .push_dat (sp_rd_data),
      .pop      (pop),
      .pop_dat  (m_tdata),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_scratchpad_stream_dma.sv
// Directed bench for scratchpad_stream_dma with a latency-accurate scratchpad read model.
// Latency: checks first-beat, done and throughput timing in cycles.
// Backpressure: exercises held-low and random m_tready.
module tb_scratchpad_stream_dma;

   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           dir = 1'b0;
   logic [AW-1:0]  cfg_base_addr = '0;
   logic [15:0]    cfg_len = '0;
   logic           busy, done, err;
   logic [DW-1:0]  s_tdata = '0;
   logic           s_tvalid = 1'b0;
   logic           s_tlast = 1'b0;
   logic           s_tready;
   logic [DW-1:0]  m_tdata;
   logic           m_tlast, m_tvalid;
   logic           m_tready = 1'b0;
   logic [AW-1:0]  sp_base_addr;
   logic           sp_wr_en;
   logic [DW-1:0]  sp_wr_data;
   logic [15:0]    sp_write_pointer;
   logic           sp_rd_en;
   logic [15:0]    sp_read_pointer;
   logic [DW-1:0]  sp_rd_data;

   int vec_cnt = 0;
   int miscmp_cnt = 0;
   int cyc = 0;

   scratchpad_stream_dma #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .dir              (dir),
      .cfg_base_addr    (cfg_base_addr),
      .cfg_len          (cfg_len),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .s_tdata          (s_tdata),
      .s_tvalid         (s_tvalid),
      .s_tlast          (s_tlast),
      .s_tready         (s_tready),
      .m_tdata          (m_tdata),
      .m_tlast          (m_tlast),
      .m_tvalid         (m_tvalid),
      .m_tready         (m_tready),
      .sp_base_addr     (sp_base_addr),
      .sp_wr_en         (sp_wr_en),
      .sp_wr_data       (sp_wr_data),
      .sp_write_pointer (sp_write_pointer),
      .sp_rd_en         (sp_rd_en),
      .sp_read_pointer  (sp_read_pointer),
      .sp_rd_data       (sp_rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scratchpad contents as a function of word address.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return 32'hDA7A_0000 ^ {19'd0, a};
   endfunction

   // Scratchpad read port: data for the addressed word appears LAT cycles later.
   logic [DW-1:0] rd_pipe [LAT];
   logic [AW-1:0] rd_addr;
   assign rd_addr = sp_base_addr + sp_read_pointer[AW-1:0];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_word(rd_addr);
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sp_rd_data = rd_pipe[LAT-1];

   // Monitor state, sampled on the falling edge.
   logic [15:0]   wr_ptr_q[$];
   logic [DW-1:0] wr_dat_q[$];
   int            wr_cyc_q[$];
   int            rd_cyc_q[$];
   logic [DW-1:0] rx_dat_q[$];
   logic          rx_last_q[$];
   int            rx_cyc_q[$];
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            both_cnt = 0;
   int            pop_total = 0;
   int            rd_ref = 0;
   int            pop_ref = 0;
   int            max_inflight = 0;

   initial begin
      int inflight;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_ref  = rd_cyc_q.size();
            pop_ref = pop_total;
         end
         if (sp_wr_en) begin
            wr_ptr_q.push_back(sp_write_pointer);
            wr_dat_q.push_back(sp_wr_data);
            wr_cyc_q.push_back(cyc);
         end
         if (sp_rd_en) rd_cyc_q.push_back(cyc);
         if (sp_wr_en && sp_rd_en) both_cnt++;
         inflight = (rd_cyc_q.size() - rd_ref) - (pop_total - pop_ref);
         if (inflight > max_inflight) max_inflight = inflight;
         if (m_tvalid && m_tready) begin
            rx_dat_q.push_back(m_tdata);
            rx_last_q.push_back(m_tlast);
            rx_cyc_q.push_back(cyc);
            pop_total++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_cmd(input logic d, input logic [AW-1:0] b, input logic [15:0] l, output int t);
      t = cyc;
      start = 1'b1;
      dir = d;
      cfg_base_addr = b;
      cfg_len = l;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata = d;
      s_tlast = l;
      @(negedge clk);
      while (!s_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         step(1);
         n++;
      end
      chk("done_seen", done_cnt - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, t2, d0, w0, r0, x0, k;

      // Reset state
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_sp_wr_en", sp_wr_en, 0);
      chk("rst_sp_rd_en", sp_rd_en, 0);
      chk("rst_base", sp_base_addr, 0);
      chk("rst_wptr", sp_write_pointer, 0);
      step(2);
      rst_n = 1'b1;
      step(2);

      // Write len=8, tlast on the final beat
      d0 = done_cnt; w0 = wr_ptr_q.size();
      start_cmd(1'b0, 13'h040, 16'd8, t);
      chk("wr_busy", busy, 1);
      chk("wr_base", sp_base_addr, 32'h040);
      for (int i = 0; i < 8; i++) send_beat(32'hA000_0000 + i, i == 7);
      wait_done(d0, 20);
      chk("wr_count", wr_ptr_q.size() - w0, 8);
      for (int i = 0; i < 8; i++) begin
         if (wr_ptr_q.size() > w0 + i) begin
            chk("wr_ptr", wr_ptr_q[w0+i], i);
            chk("wr_dat", wr_dat_q[w0+i], 32'hA000_0000 + i);
         end
      end
      chk("wr_first_cyc", wr_cyc_q[w0], t + 1);
      chk("wr_back_to_back", wr_cyc_q[w0+7] - wr_cyc_q[w0], 7);
      chk("wr_done_lat", done_cyc - wr_cyc_q[w0+7], 1);
      chk("wr_err", err, 0);
      chk("wr_idle", busy, 0);

      // Write len=8, early tlast on beat 4
      d0 = done_cnt; w0 = wr_ptr_q.size();
      start_cmd(1'b0, 13'h080, 16'd8, t);
      for (int i = 0; i < 5; i++) send_beat(32'hB000_0000 + i, i == 4);
      wait_done(d0, 20);
      chk("early_count", wr_ptr_q.size() - w0, 5);
      chk("early_last_ptr", wr_ptr_q[w0+4], 4);
      chk("early_err", err, 1);
      chk("early_idle", busy, 0);
      step(1);
      chk("early_s_tready", s_tready, 0);

      // Read len=16, m_tready held high
      m_tready = 1'b1;
      d0 = done_cnt; r0 = rd_cyc_q.size(); x0 = rx_dat_q.size();
      start_cmd(1'b1, 13'h100, 16'd16, t);
      chk("rd_err_cleared", err, 0);
      wait_done(d0, 100);
      chk("rd_req_count", rd_cyc_q.size() - r0, 16);
      chk("rd_beat_count", rx_dat_q.size() - x0, 16);
      if (rx_dat_q.size() >= x0 + 16 && rd_cyc_q.size() >= r0 + 1) begin
         for (int i = 0; i < 16; i++) begin
            chk("rd_dat", rx_dat_q[x0+i], 32'hDA7A_0000 ^ (32'h100 + i));
            chk("rd_last", rx_last_q[x0+i], (i == 15) ? 1 : 0);
         end
         chk("rd_first_req", rd_cyc_q[r0], t + 1);
         chk("rd_first_beat_lat", rx_cyc_q[x0] - rd_cyc_q[r0], LAT + 1);
         chk("rd_throughput", rx_cyc_q[x0+15] - rx_cyc_q[x0], 15);
         chk("rd_done_lat", done_cyc - rx_cyc_q[x0+15], 1);
      end

      // Read len=16 across the address wrap, m_tready low 10 cycles then random
      m_tready = 1'b0;
      d0 = done_cnt; r0 = rd_cyc_q.size(); x0 = rx_dat_q.size();
      start_cmd(1'b1, 13'h1FF8, 16'd16, t);
      k = 0;
      while (done_cnt == d0 && k < 600) begin
         k++;
         m_tready = (k <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
         step(1);
      end
      m_tready = 1'b1;
      chk("bp_done", done_cnt - d0, 1);
      chk("bp_req_count", rd_cyc_q.size() - r0, 16);
      chk("bp_beat_count", rx_dat_q.size() - x0, 16);
      if (rx_dat_q.size() >= x0 + 16) begin
         for (int i = 0; i < 16; i++) begin
            chk("bp_dat", rx_dat_q[x0+i], 32'hDA7A_0000 ^ ((32'h1FF8 + i) & 32'h1FFF));
            chk("bp_last", rx_last_q[x0+i], (i == 15) ? 1 : 0);
         end
      end
      chk("bp_max_inflight", max_inflight, DEPTH);

      // Zero-length write, with a start strobe while busy
      d0 = done_cnt; w0 = wr_ptr_q.size(); r0 = rd_cyc_q.size();
      start_cmd(1'b0, 13'h055, 16'd0, t);
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 1);
      start_cmd(1'b1, 13'h123, 16'd4, t2);
      chk("busy_start_ignored_state", busy, 0);
      chk("busy_start_ignored_base", sp_base_addr, 32'h055);
      step(5);
      chk("len0_done_cnt", done_cnt - d0, 1);
      chk("len0_done_cyc", done_cyc, t + 1);
      chk("len0_no_wr", wr_ptr_q.size() - w0, 0);
      chk("len0_no_rd", rd_cyc_q.size() - r0, 0);

      // Zero-length read
      d0 = done_cnt; r0 = rd_cyc_q.size();
      start_cmd(1'b1, 13'h066, 16'd0, t);
      chk("len0rd_done", done, 1);
      step(3);
      chk("len0rd_no_rd", rd_cyc_q.size() - r0, 0);
      chk("len0rd_done_cnt", done_cnt - d0, 1);

      // Reset mid-read with words in flight
      m_tready = 1'b0;
      start_cmd(1'b1, 13'h200, 16'd16, t);
      step(3);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_m_tvalid", m_tvalid, 0);
      chk("abort_m_tlast", m_tlast, 0);
      chk("abort_sp_rd_en", sp_rd_en, 0);
      chk("abort_s_tready", s_tready, 0);
      chk("abort_base", sp_base_addr, 0);
      chk("abort_rptr", sp_read_pointer, 0);
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_fifo_flushed", m_tvalid, 0);
      m_tready = 1'b1;
      x0 = rx_dat_q.size();
      start_cmd(1'b1, 13'h010, 16'd4, t);
      wait_done(d0, 50);
      step(3);
      chk("post_rst_count", rx_dat_q.size() - x0, 4);
      if (rx_dat_q.size() >= x0 + 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("post_rst_dat", rx_dat_q[x0+i], 32'hDA7A_0000 ^ (32'h010 + i));
            chk("post_rst_last", rx_last_q[x0+i], (i == 3) ? 1 : 0);
         end
      end

      chk("no_wr_rd_overlap", both_cnt, 0);
      chk("inflight_le_depth", (max_inflight <= DEPTH) ? 1 : 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
